// File: rtl/lambert_shade_unit_pkg.sv
// lambert_pkg: shared widths, Q1.14 constants, vector/colour types and FSM states for the Lambert shader
package lambert_pkg;
  localparam int VW = 16;
  localparam int FRAC = 14;
  localparam int CW = 8;
  localparam logic [VW-1:0] ONE_Q14 = 16'h4000;
  typedef struct packed {
    logic signed [VW-1:0] x, y, z;
  } vec3_t;
  typedef struct packed {
    logic [CW-1:0] r, g, b;
  } rgb_t;
  typedef enum logic [2:0] {IDLE, MAC_X, MAC_Y, MAC_Z, CLAMP, SCALE, DONE} shade_state_t;
  // intensity never exceeds 1.0, so the product fits in CW+FRAC bits and the result in CW bits
  function automatic logic [CW-1:0] scale_ch(input logic [CW-1:0] c, input logic [FRAC:0] i);
    logic [CW+FRAC-1:0] p;
    p = c * i;
    return p[CW+FRAC-1:FRAC];
  endfunction
endpackage

// File: rtl/lambert_shade_unit_if.sv
// lambert_shade_unit_if: vector-in / shaded-colour-out valid/ready bus
interface lambert_shade_unit_if;
  import lambert_pkg::*;
  logic in_valid;
  logic in_ready;
  logic signed [VW-1:0] norm_x, norm_y, norm_z;
  logic signed [VW-1:0] light_x, light_y, light_z;
  logic [3*CW-1:0] base_color;
  logic out_valid;
  logic out_ready;
  logic [3*CW-1:0] out_color;
  logic [VW-1:0] out_intensity;
  modport master (
    output in_valid, norm_x, norm_y, norm_z, light_x, light_y, light_z, base_color, out_ready,
    input in_ready, out_valid, out_color, out_intensity
  );
  modport slave (
    input in_valid, norm_x, norm_y, norm_z, light_x, light_y, light_z, base_color, out_ready,
    output in_ready, out_valid, out_color, out_intensity
  );
endinterface

// File: rtl/lambert_shade_unit_q14_mul.sv
// q14_mul: combinational signed VW x VW multiplier shared by all MAC steps
module q14_mul
  import lambert_pkg::*;
(
  input  logic signed [VW-1:0]   a,
  input  logic signed [VW-1:0]   b,
  output logic signed [2*VW-1:0] p
);
  assign p = a * b;
endmodule

// File: rtl/lambert_shade_unit.sv
// lambert_shade_unit: sequential N.L dot product, clamp to [0,1.0], and RGB888 scaling
module lambert_shade_unit
  import lambert_pkg::*;
(
  input logic clk,
  input logic rst,
  lambert_shade_unit_if.slave bus
);
  shade_state_t state, state_next;
  vec3_t n, l;
  rgb_t col;
  logic signed [2*VW+1:0] acc, t, prod_ext;
  logic signed [VW-1:0] ma, mb;
  logic signed [2*VW-1:0] prod;
  logic [FRAC:0] i_q, i_next;
  assign ma = (state == MAC_X) ? n.x : (state == MAC_Y) ? n.y : n.z;
  assign mb = (state == MAC_X) ? l.x : (state == MAC_Y) ? l.y : l.z;
  q14_mul u_mul (.a(ma), .b(mb), .p(prod));
  assign prod_ext = {{2{prod[2*VW-1]}}, prod};
  assign t = acc >>> FRAC;
  assign i_next = (acc <= 0) ? '0 : (t >= 34'sh4000) ? ONE_Q14[FRAC:0] : t[FRAC:0];
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  always_comb begin
    state_next = (state == IDLE) ? (bus.in_valid ? MAC_X : IDLE)
               : (state == DONE) ? (bus.out_ready ? IDLE : DONE)
               : shade_state_t'(state + 3'd1);
  end
  always_comb begin
    bus.in_ready = (state == IDLE);
    bus.out_valid = (state == DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n <= '0;
      l <= '0;
      col <= '0;
      acc <= '0;
      i_q <= '0;
      bus.out_color <= '0;
      bus.out_intensity <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        n <= {bus.norm_x, bus.norm_y, bus.norm_z};
        l <= {bus.light_x, bus.light_y, bus.light_z};
        col <= bus.base_color;
      end
      if (state == MAC_X) acc <= prod_ext;
      if (state == MAC_Y || state == MAC_Z) acc <= acc + prod_ext;
      if (state == CLAMP) i_q <= i_next;
      if (state == SCALE) begin
        bus.out_color <= {scale_ch(col.r, i_q), scale_ch(col.g, i_q), scale_ch(col.b, i_q)};
        bus.out_intensity <= {1'b0, i_q};
      end
    end
  end
endmodule
